// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
//   Shared definitions for the two-port ALU share arbiter.
//   - ALU control code constants (AND, OR, ADD, SUB, PASS_B)
//   - FSM state type used by alu_share_arbiter
//   - is_supported_ctrl(): true for the five control codes the ALU implements.
//     It is used only when ALU_CTRL_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    localparam logic [3:0] CTRL_AND    = 4'b0000;
    localparam logic [3:0] CTRL_OR     = 4'b0001;
    localparam logic [3:0] CTRL_ADD    = 4'b0010;
    localparam logic [3:0] CTRL_SUB    = 4'b0110;
    localparam logic [3:0] CTRL_PASS_B = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // The argument is taken as 32 bits so callers with any CTRL_W can pass
    // their code zero-extended. Upper bits that are set never match a code.
    function automatic logic is_supported_ctrl(input logic [31:0] c);
        return (c == 32'(CTRL_AND))  || (c == 32'(CTRL_OR))  ||
               (c == 32'(CTRL_ADD))  || (c == 32'(CTRL_SUB)) ||
               (c == 32'(CTRL_PASS_B));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-requester round-robin arbiter. This block is purely combinational.
//   When both ports request, the port that was NOT granted last wins.
//   Ports:
//     req[1:0]    request bits, one per port
//     last_grant  index of the port granted most recently
//     en          when low, no port is granted
//     gnt[1:0]    one-hot grant (all zeros when idle or disabled)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11)
                gnt = last_grant ? 2'b01 : 2'b10;
            else
                gnt = req;  // zero or one requester: the grant is the request itself
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. The block picks a
//   requester round-robin and latches its operands. It drives the ALU for one
//   cycle, then registers the result and zero flag and holds them until the
//   consumer accepts them. Only one operation is in flight at a time.
//   The latency from a request handshake to resp_valid is 2 cycles.
//   With resp_ready held high, throughput is 1 operation per 3 cycles.
//
//   Optional feature (macro ALU_CTRL_CHECK_EN):
//     When defined, an unsupported control code is still executed. The
//     response then reports resp_err=1 and forces resp_data and resp_zero to 0.
//     When undefined, resp_err is tied to 0 and the ALU output is passed through.
//
//   Ports:
//     clk, reset              clock and synchronous active-high reset
//     req_valid/req_ready     per-port request handshake (bit i = port i)
//     req_a/req_b/req_ctrl    per-port operands and control code, packed by port
//     alu_a/alu_b/alu_c       operands to the shared ALU (always from the latches)
//     alu_r/alu_zero          ALU result and zero flag, sampled only in EXEC
//     resp_valid/resp_ready   response handshake
//     resp_id                 port that owns the response
//     resp_data/resp_zero     registered result and zero flag
//     resp_err                unsupported control code flag
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*WIDTH-1:0]    req_a,
    input  logic [2*WIDTH-1:0]    req_b,
    input  logic [2*CTRL_W-1:0]   req_ctrl,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [CTRL_W-1:0]     alu_c,
    input  logic [WIDTH-1:0]      alu_r,
    input  logic                  alu_zero,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_zero,
    output logic                  resp_err
);

    state_e              state_q;
    logic                last_grant_q;
    logic [WIDTH-1:0]    a_q, b_q;
    logic [CTRL_W-1:0]   c_q;
    logic                resp_valid_q, resp_id_q, resp_zero_q;
    logic [WIDTH-1:0]    resp_data_q;

    logic [1:0]          gnt;
    logic [WIDTH-1:0]    a_d, b_d;
    logic [CTRL_W-1:0]   c_d;

    // Gating the arbiter with reset keeps req_ready low during reset cycles.
    // Without this, a requester could see a handshake that the reset branch
    // then discards.
    rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .en         ((state_q == ST_IDLE) && !reset),
        .gnt        (gnt)
    );

    assign req_ready = gnt;

    // Operand mux for the granted port. The grant is one-hot, so gnt[1] is the port index.
    always_comb begin
        a_d = gnt[1] ? req_a[2*WIDTH-1:WIDTH]     : req_a[WIDTH-1:0];
        b_d = gnt[1] ? req_b[2*WIDTH-1:WIDTH]     : req_b[WIDTH-1:0];
        c_d = gnt[1] ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
    end

    // The ALU always sees the latches, so its inputs change only at a grant.
    assign alu_a = a_q;
    assign alu_b = b_q;
    assign alu_c = c_q;

`ifdef ALU_CTRL_CHECK_EN
    logic resp_err_q;
    logic ctrl_ok;
    assign ctrl_ok = is_supported_ctrl(32'(c_q));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;      // port 0 wins the first contention
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
`ifdef ALU_CTRL_CHECK_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        a_q          <= a_d;
                        b_q          <= b_d;
                        c_q          <= c_d;
                        last_grant_q <= gnt[1];
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // last_grant_q still names the owner of this operation.
                    resp_id_q    <= last_grant_q;
                    resp_valid_q <= 1'b1;
`ifdef ALU_CTRL_CHECK_EN
                    if (!ctrl_ok) begin
                        resp_data_q <= '0;
                        resp_zero_q <= 1'b0;
                        resp_err_q  <= 1'b1;
                    end else begin
                        resp_data_q <= alu_r;
                        resp_zero_q <= alu_zero;
                        resp_err_q  <= 1'b0;
                    end
`else
                    resp_data_q  <= alu_r;
                    resp_zero_q  <= alu_zero;
`endif
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    // resp_valid_q is always high here, so resp_ready alone completes the handshake.
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_zero  = resp_zero_q;
`ifdef ALU_CTRL_CHECK_EN
    assign resp_err   = resp_err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter. A stand-in combinational ALU is
//   attached to the alu_* ports. The tests are directed scenarios followed by a
//   randomized run, checked against a transaction-level model: a grant order,
//   a two-cycle latency and the expected arithmetic per control code.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int W  = 64;
    localparam int CW = 4;
    localparam logic [63:0] JUNK = 64'hA5A5_5A5A_0F0F_F0F0;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_valid, req_ready;
    logic [2*W-1:0]  req_a, req_b;
    logic [2*CW-1:0] req_ctrl;
    logic [W-1:0]    alu_a, alu_b, alu_r;
    logic [CW-1:0]   alu_c;
    logic            alu_zero;
    logic            resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [W-1:0]    resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_r(alu_r), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err)
    );

    // Stand-in shared ALU. Undefined codes produce a recognisable junk value.
    always_comb begin
        alu_r = alu_a ^ alu_b ^ JUNK;
        case (alu_c)
            4'b0000: alu_r = alu_a & alu_b;
            4'b0001: alu_r = alu_a | alu_b;
            4'b0010: alu_r = alu_a + alu_b;
            4'b0110: alu_r = alu_a - alu_b;
            4'b0111: alu_r = alu_b;
            default: ;
        endcase
        alu_zero = (alu_r == '0);
    end

    // Expected response {err, zero, data} for one operation.
    function automatic logic [65:0] ref_resp(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        bit ok;
        ok = 1;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = b;
            default: begin r = a ^ b ^ JUNK; ok = 0; end
        endcase
`ifdef ALU_CTRL_CHECK_EN
        if (!ok) return {1'b1, 1'b0, 64'd0};
`endif
        return {1'b0, (r == 64'd0), r};
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1; req_valid = 0; resp_ready = 0; req_a = '0; req_b = '0; req_ctrl = '0;
        tick; tick;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); end
        checks++; if (resp_data !== 64'd0 || resp_zero !== 1'b0 || resp_id !== 1'b0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_resp: data=%0h zero=%b id=%b err=%b exp all 0", resp_data, resp_zero, resp_id, resp_err); end
        checks++; if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_c !== 4'd0) begin
            errors++; $display("FAIL reset_latches: a=%0h b=%0h c=%0h exp 0", alu_a, alu_b, alu_c); end
        tick; reset = 0;
    endtask

    task automatic test_single;
        req_valid = 2'b01; req_a = {64'd0, 64'd5}; req_b = {64'd0, 64'd7}; req_ctrl = {4'd0, 4'b0010}; resp_ready = 1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b exp 01", req_ready); end
        tick; req_valid = 0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL single_exec: rv=%b rr=%b exp 0/00", resp_valid, req_ready); end
        checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7 || alu_c !== 4'b0010) begin
            errors++; $display("FAIL single_alu_in: a=%0h b=%0h c=%0h exp 5/7/2", alu_a, alu_b, alu_c); end
        tick; @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 64'd12 || resp_zero !== 1'b0 || resp_id !== 1'b0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL single_resp: rv=%b data=%0h zero=%b id=%b err=%b exp 1/c/0/0/0", resp_valid, resp_data, resp_zero, resp_id, resp_err); end
        tick; @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_accept: rv=%b exp 0", resp_valid); end
        tick;
    endtask

    task automatic test_zero;
        req_valid = 2'b10; req_a = {64'hFFFF_FFFF_FFFF_FFFF, 64'd0}; req_b = {64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        req_ctrl = {4'b0110, 4'd0}; resp_ready = 1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_grant: got %b exp 10", req_ready); end
        tick; req_valid = 0; tick;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 64'd0 || resp_zero !== 1'b1 || resp_id !== 1'b1) begin
            errors++; $display("FAIL zero_resp: rv=%b data=%0h zero=%b id=%b exp 1/0/1/1", resp_valid, resp_data, resp_zero, resp_id); end
        tick; tick;
    endtask

    // Both ports request continuously, so grants alternate every 3 cycles.
    task automatic test_contention;
        logic [1:0] er;
        logic [63:0] ed;
        req_valid = 2'b11; req_a = {64'hF0, 64'hF0}; req_b = {64'h0F, 64'h3C}; req_ctrl = {4'b0001, 4'b0000}; resp_ready = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            er = (cyc % 3 == 0) ? (((cyc / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++; if (req_ready !== er) begin errors++; $display("FAIL contention_grant c%0d: got %b exp %b", cyc, req_ready, er); end
            if (cyc % 3 == 2) begin
                ed = (((cyc / 3) % 2) == 0) ? 64'h30 : 64'hFF;
                checks++; if (resp_valid !== 1'b1 || resp_data !== ed || resp_id !== 1'((cyc / 3) % 2)) begin
                    errors++; $display("FAIL contention_resp c%0d: rv=%b data=%0h id=%b exp data %0h", cyc, resp_valid, resp_data, resp_id, ed); end
            end
            tick;
        end
        req_valid = 0;
        tick;
    endtask

    task automatic test_backpressure;
        req_valid = 2'b01; req_a = {64'd0, 64'd1}; req_b = {64'h55, 64'd2}; req_ctrl = {4'b0111, 4'b0010}; resp_ready = 0;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant0: got %b exp 01", req_ready); end
        tick; req_valid = 2'b10; tick;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1 || resp_data !== 64'd3 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
                errors++; $display("FAIL bp_hold%0d: rv=%b data=%0h id=%b rr=%b exp 1/3/0/00", i, resp_valid, resp_data, resp_id, req_ready); end
            tick;
        end
        resp_ready = 1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_accept: rv=%b rr=%b exp 1/00", resp_valid, req_ready); end
        tick; @(negedge clk);
        checks++; if (req_ready !== 2'b10 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_regrant: rr=%b rv=%b exp 10/0", req_ready, resp_valid); end
        tick; req_valid = 0; tick; @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 64'h55 || resp_id !== 1'b1) begin
            errors++; $display("FAIL bp_resp1: rv=%b data=%0h id=%b exp 1/55/1", resp_valid, resp_data, resp_id); end
        tick; tick;
    endtask

    task automatic test_reset_midop;
        req_valid = 2'b01; req_a = {64'hF0, 64'hF0}; req_b = {64'h0F, 64'h3C}; req_ctrl = {4'b0001, 4'b0000}; resp_ready = 1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_mid_grant: got %b exp 01", req_ready); end
        tick; req_valid = 2'b11; reset = 1;   // EXEC cycle with reset asserted, both ports waiting
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_mid_exec_rr: got %b exp 00", req_ready); end
        tick; reset = 0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || resp_data !== 64'd0) begin errors++; $display("FAIL rst_mid_drop: rv=%b data=%0h exp 0/0", resp_valid, resp_data); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_mid_regrant: got %b exp 01", req_ready); end
        tick; req_valid = 0; tick; @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 64'h30 || resp_id !== 1'b0) begin
            errors++; $display("FAIL rst_mid_resp: rv=%b data=%0h id=%b exp 1/30/0", resp_valid, resp_data, resp_id); end
        tick; tick;
    endtask

    task automatic test_unsupported;
        logic [65:0] e;
        e = ref_resp(4'b1100, 64'h1234, 64'h1234);
        req_valid = 2'b01; req_a = {64'd0, 64'h1234}; req_b = {64'd0, 64'h1234}; req_ctrl = {4'd0, 4'b1100}; resp_ready = 1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL unsup_grant: got %b exp 01", req_ready); end
        tick; req_valid = 0; tick; @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || {resp_err, resp_zero, resp_data} !== e) begin
            errors++; $display("FAIL unsup_resp: err=%b zero=%b data=%0h exp %0h", resp_err, resp_zero, resp_data, e); end
        tick; tick;
    endtask

    // Randomized traffic against a transaction-level model: each port holds
    // its request until it is granted. A grant is possible only while nothing
    // is in flight. The response appears 2 cycles after its grant and is held
    // until accepted.
    task automatic test_random;
        logic [1:0]  pend;
        logic [63:0] pa [2];
        logic [63:0] pb [2];
        logic [3:0]  pc [2];
        logic [3:0]  codes [7];
        logic [65:0] er;
        logic [63:0] ea, eb;
        logic [3:0]  ec;
        logic [1:0]  exp_rr;
        int last, t_grant, w, eid;
        bit inflight, exp_rv, acc;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};
        reset = 1; req_valid = 0; resp_ready = 0; tick; reset = 0;
        pend = 0; last = 1; inflight = 0; t_grant = -10; eid = 0; er = '0; ea = '0; eb = '0; ec = '0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; pc[0] = '0; pc[1] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    pa[p] = {$urandom, $urandom};
                    pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : {$urandom, $urandom};
                    pc[p] = codes[$urandom_range(0, ($urandom_range(0, 5) == 0) ? 6 : 4)];
                end
            end
            req_valid = pend; req_a = {pa[1], pa[0]}; req_b = {pb[1], pb[0]}; req_ctrl = {pc[1], pc[0]};
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            w = -1;
            if (!inflight && pend != 2'b00) w = (pend == 2'b11) ? 1 - last : (pend[0] ? 0 : 1);
            exp_rr = (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10);
            exp_rv = inflight && (cyc >= t_grant + 2);
            checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL rand_grant c%0d: got %b exp %b", cyc, req_ready, exp_rr); end
            checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL rand_rv c%0d: got %b exp %b", cyc, resp_valid, exp_rv); end
            if (inflight && cyc == t_grant + 1) begin
                checks++; if (alu_a !== ea || alu_b !== eb || alu_c !== ec) begin
                    errors++; $display("FAIL rand_alu_in c%0d: a=%0h b=%0h c=%0h exp %0h/%0h/%0h", cyc, alu_a, alu_b, alu_c, ea, eb, ec); end
            end
            if (exp_rv) begin
                checks++; if ({resp_err, resp_zero, resp_data} !== er || resp_id !== 1'(eid)) begin
                    errors++; $display("FAIL rand_resp c%0d: err=%b zero=%b data=%0h id=%b exp %0h id %0d", cyc, resp_err, resp_zero, resp_data, resp_id, er, eid); end
            end
            acc = exp_rv && resp_ready;
            if (w >= 0) begin
                t_grant = cyc; eid = w; last = w; inflight = 1;
                ea = pa[w]; eb = pb[w]; ec = pc[w]; er = ref_resp(pc[w], pa[w], pb[w]);
                pend[w] = 0;
            end
            if (acc) inflight = 0;
            tick;
        end
        req_valid = 0; resp_ready = 1; tick; tick; tick;
    endtask

    initial begin
        reset = 1; req_valid = 0; resp_ready = 0; req_a = '0; req_b = '0; req_ctrl = '0;
        test_reset;
        test_single;
        test_zero;
        test_contention;
        test_backpressure;
        test_reset_midop;
        test_unsupported;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 64-bit ALU between two requesters, port 0 and port 1.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, latches the operands, drives the ALU for one cycle and registers the result and zero flag.
- The response is held until it is accepted. Sits between the issue logic and the shared ALU.

Parameters:
- WIDTH, 64, operand and result width.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-port request valid; bit i belongs to port i.
- req_ready  output  2  per-port request accepted this cycle.
- req_a  input  2*WIDTH  operand A; port i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  2*WIDTH  operand B, packed the same way.
- req_ctrl  input  2*CTRL_W  ALU control code per port.
- alu_a  output  WIDTH  operand A to the ALU.
- alu_b  output  WIDTH  operand B to the ALU.
- alu_c  output  CTRL_W  control code to the ALU.
- alu_r  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.
- resp_valid  output  1  response available.
- resp_ready  input  1  response consumer accepts.
- resp_id  output  1  port that owns the response.
- resp_data  output  WIDTH  registered result.
- resp_zero  output  1  registered zero flag.
- resp_err  output  1  unsupported control code; only driven when ALU_CTRL_CHECK_EN is defined, otherwise tied to 0.

Behaviour:
- Supported control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, PASS_B 0111.
- State machine states:
  - IDLE: arbitrate among requesting ports.
  - EXEC: ALU inputs driven from the latched operands.
  - RESP: result held.
- Reset (synchronous): state=IDLE, last_grant=1 (so port 0 wins first), req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_zero=0, resp_err=0, operand latches=0.
- IDLE:
  - If any req_valid bit is set, grant one port. Round-robin: prefer the port that is not last_grant.
  - Assert req_ready for the granted port only, combinationally, in the same cycle. The request handshake completes in that cycle.
  - On that edge: latch A, B and ctrl; set last_grant to the granted port; go to EXEC.
  - req_ready is 0 in every other state.
- EXEC:
  - alu_a, alu_b and alu_c come from the latches.
  - At the clock edge: capture alu_r into resp_data and alu_zero into resp_zero; set resp_id; set resp_valid=1; go to RESP.
- RESP:
  - resp_* are stable while resp_valid=1 and resp_ready=0.
  - When resp_valid and resp_ready are both high: clear resp_valid and go to IDLE.
  - No bypass: the earliest next grant is the cycle after the response is accepted.
- ALU inputs outside EXEC still come from the latches, so they are stable. The ALU output is sampled only in EXEC.
- Timing:
  - Latency from request handshake to resp_valid is 2 cycles.
  - Throughput is 1 op per 3 cycles with resp_ready held high.
- Simultaneous requests: exactly one grant; the other port waits. A requester must hold req_valid and its operands until req_ready.
- Only one operation is in flight at a time.
- Reset asserted in any state aborts the in-flight operation and drops the response; the block returns to the reset values on the next edge.
- All arithmetic is performed in the ALU. The block adds no width extension or truncation.

Optional Feature:
- Macro: ALU_CTRL_CHECK_EN.
- Defined:
  - An unsupported control code is still granted and executed.
  - resp_err=1 is registered with the response.
  - resp_data=0 and resp_zero=0 are forced, so an undefined ALU result never propagates.
- Undefined:
  - No check is made; resp_err is a constant 0.
  - resp_data and resp_zero are whatever the ALU produced.

Decomposition:
- Package alu_ctrl_pkg holds:
  - localparams for the five control codes;
  - the state enum typedef (IDLE/EXEC/RESP);
  - a function is_supported_ctrl.
- One sub-module, rr_arbiter2: two-requester round-robin. Inputs are req[1:0], last_grant and an enable; output is a one-hot grant.
- Everything else stays in the top module.

Test Plan:
- Single request: port 0, ctrl=0010, A=5, B=7 -> req_ready[0] in cycle 0, resp_valid in cycle 2 with resp_data=12, resp_zero=0, resp_id=0.
- Zero flag: port 1, ctrl=0110, A=B=64'hFFFF_FFFF_FFFF_FFFF -> resp_data=0, resp_zero=1, resp_id=1.
- Contention: both ports valid continuously (port 0 AND 0xF0&0x3C; port 1 OR 0xF0|0x0F) -> grants alternate 0,1,0,1; responses are 0x30 and 0xFF in the same order.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* are stable, req_ready stays 0; one cycle after resp_ready=1, a new grant occurs.
- Reset mid-op: reset asserted in EXEC -> next cycle resp_valid=0, state IDLE; after release, a waiting port 0 request is granted first.
- Unsupported code: ctrl=1100 with the macro defined -> resp_err=1, resp_data=0, resp_zero=0. Without the macro -> resp_err=0.
